fetch_ibuf: RTL

Instruction fetch buffer on the consumer side of the PC register. Each cycle it accepts the fetch address the PC register presents, issues a read to the synchronous instruction memory, and pairs the returned word with its PC. It queues these pairs in a small FIFO and hands them to decode with a valid/ready handshake. It drives `stall_o` back to the PC register when it has no room, and discards all queued and in-flight fetches when a jump redirects the stream.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/fetch_ibuf_fifo.sv | 91 +++++++++
 rtl/fetch_ibuf.sv | 117 +++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch buffer:
//   XLEN          - PC and instruction width
//   RESET_PC      - PC value held in the pending-PC register out of reset
//   fetch_entry_t - one queued fetch: {inst, pc}
//   make_entry()  - builds a fetch_entry_t from a returned word and its PC
// -----------------------------------------------------------------------------
package fetch_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic fetch_entry_t make_entry(input logic [XLEN-1:0] inst,
                                                input logic [XLEN-1:0] pc);
        fetch_entry_t e;
        e.inst = inst;
        e.pc   = pc;
        return e;
    endfunction

endpackage

// File: rtl/fetch_ibuf_fifo.sv
// -----------------------------------------------------------------------------
// fetch_ibuf_fifo
// DEPTH-entry synchronous FIFO of fetch_entry_t.
// Ports:
//   clk, rst   clock, asynchronous active-low reset
//   push/wdata write an entry (ignored while full)
//   pop        advance the head (ignored while empty)
//   clear      synchronous clear of pointers and count, wins over push/pop
//   head       entry at the read pointer (meaningless while empty)
//   count      occupancy 0..DEPTH
//   empty/full occupancy flags
// Storage is not reset: entries are only observable through count.
// -----------------------------------------------------------------------------
module fetch_ibuf_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  fetch_entry_t             wdata,
    input  logic                     pop,
    input  logic                     clear,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_EMPTY = CW'(0);

    fetch_entry_t    mem_r [DEPTH];
    logic [AW-1:0]   wr_ptr_r;
    logic [AW-1:0]   rd_ptr_r;
    logic [CW-1:0]   count_r;
    logic            push_s;
    logic            pop_s;

    // Qualify requests so a misbehaving caller can never corrupt the count.
    always_comb begin
        push_s = push & ~clear & (count_r != CNT_FULL);
        pop_s  = pop  & ~clear & (count_r != CNT_EMPTY);
    end

    // Pointer and occupancy state; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_EMPTY;
        end else if (clear) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= CNT_EMPTY;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Head and status outputs.
    always_comb begin
        head  = mem_r[rd_ptr_r];
        count = count_r;
        empty = (count_r == CNT_EMPTY);
        full  = (count_r == CNT_FULL);
    end

endmodule

// File: rtl/fetch_ibuf.sv
// -----------------------------------------------------------------------------
// fetch_ibuf
// Instruction fetch buffer between the PC register and decode. Issues one
// synchronous memory read per accepted PC, pairs the returned word with its
// PC and queues the pair for decode. Jumps (flush) discard queued and
// in-flight fetches.
// Ports:
//   clk, rst              clock, asynchronous active-low reset
//   pc_i, pc_valid        fetch request from the PC register
//   stall_o               no credit; PC register must hold pc_i
//   flush                 jump taken; drop everything this cycle
//   imem_en, imem_addr    memory read request (addr = pc_i)
//   imem_rdata            read data, valid the cycle after imem_en
//   inst_o, inst_pc_o     head instruction and its PC
//   inst_valid/inst_ready decode handshake
// Build option:
//   FETCH_IBUF_BYPASS_EN  forward the returning word straight to decode when
//                         the FIFO is empty (1-cycle latency). Without it all
//                         decode outputs come from registered FIFO state.
// Note: entries use fetch_pkg::fetch_entry_t, so XLEN must match
// fetch_pkg::XLEN.
// -----------------------------------------------------------------------------
module fetch_ibuf #(
    parameter int DEPTH = 4,
    parameter int XLEN  = fetch_pkg::XLEN
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] pc_i,
    input  logic            pc_valid,
    output logic            stall_o,
    input  logic            flush,
    output logic            imem_en,
    output logic [XLEN-1:0] imem_addr,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] inst_o,
    output logic [XLEN-1:0] inst_pc_o,
    output logic            inst_valid,
    input  logic            inst_ready
);

    import fetch_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW:0] OCC_LIMIT = (CW+1)'(DEPTH);

    logic [CW-1:0]   count_s;
    logic            empty_s;
    logic            full_s;
    fetch_entry_t    head_s;
    fetch_entry_t    wdata_s;

    logic            inflight_r;
    logic [XLEN-1:0] pend_pc_r;

    logic [CW:0]     occupancy_s;
    logic            credit_s;
    logic            issue_s;
    logic            push_s;
    logic            pop_s;
    logic            bypass_s;

    // Credit counts the in-flight read as occupied so its return always fits.
    always_comb begin
        occupancy_s = {1'b0, count_s} + {{CW{1'b0}}, inflight_r};
        credit_s    = (occupancy_s < OCC_LIMIT);
        issue_s     = pc_valid & credit_s & ~flush;
        wdata_s     = make_entry(imem_rdata, pend_pc_r);
`ifdef FETCH_IBUF_BYPASS_EN
        // Returning word goes straight to decode when nothing is queued ahead.
        bypass_s    = empty_s & inflight_r & ~flush;
        push_s      = inflight_r & ~flush & ~full_s & ~(bypass_s & inst_ready);
        inst_valid  = (~empty_s | bypass_s) & ~flush;
        inst_o      = bypass_s ? imem_rdata : head_s.inst;
        inst_pc_o   = bypass_s ? pend_pc_r  : head_s.pc;
`else
        bypass_s    = 1'b0;
        push_s      = inflight_r & ~flush & ~full_s;
        inst_valid  = ~empty_s & ~flush;
        inst_o      = head_s.inst;
        inst_pc_o   = head_s.pc;
`endif
        pop_s       = ~empty_s & inst_ready & ~flush;
        stall_o     = ~credit_s;
        imem_en     = issue_s;
        imem_addr   = pc_i;
    end

    // In-flight tracking: one outstanding read whose PC is held for pairing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_r <= 1'b0;
            pend_pc_r  <= XLEN'(RESET_PC);
        end else begin
            inflight_r <= issue_s;
            if (issue_s) begin
                pend_pc_r <= pc_i;
            end
        end
    end

    fetch_ibuf_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .wdata (wdata_s),
        .pop   (pop_s),
        .clear (flush),
        .head  (head_s),
        .count (count_s),
        .empty (empty_s),
        .full  (full_s)
    );

endmodule
